// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one combinational-read memory port between
// instruction fetch (read-only) and load/store (read/write) requesters.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_ack,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy
);

   localparam int unsigned   CntW    = $clog2(WAIT_CYCLES) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

   // Requester id: 0 = IF, 1 = LS
   localparam logic GntIf = 1'b0;
   localparam logic GntLs = 1'b1;

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              last_q, last_d;
   logic              win_q, win_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
   logic              winner;

   // State and datapath registers; reset abandons any access in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         last_q     <= GntLs;
         win_q      <= GntIf;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         win_q      <= win_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         ls_rdata_q <= ls_rdata_d;
      end
   end

   // Next-state: grant in IDLE, count out the access, then one RESP cycle
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      win_d      = win_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      ls_rdata_d = ls_rdata_q;
      winner     = GntIf;
      unique case (state_q)
         StIdle: begin
            if (if_req || ls_req) begin
               // On a tie the requester that did not win last time goes first
               winner  = (if_req && ls_req) ? ~last_q : ls_req;
               win_d   = winner;
               addr_d  = (winner == GntLs) ? ls_addr : if_addr;
               we_d    = (winner == GntLs) && ls_we;
               wdata_d = (winner == GntLs) ? ls_wdata : wdata_q;
               cnt_d   = '0;
               state_d = StAccess;
            end
         end
         StAccess: begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
               if (!we_q) begin
                  if (win_q == GntLs) ls_rdata_d = mem_dout;
                  else                if_rdata_d = mem_dout;
               end
               state_d = StResp;
            end
         end
         StResp: begin
            last_d  = win_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decode from registered state only
   always_comb begin
      if_ack   = (state_q == StResp) && (win_q == GntIf);
      ls_ack   = (state_q == StResp) && (win_q == GntLs);
      mem_we   = (state_q == StAccess) && we_q;
      mem_addr = addr_q;
      mem_din  = wdata_q;
      busy     = (state_q != StIdle);
      if_rdata = if_rdata_q;
      ls_rdata = ls_rdata_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: WAIT_CYCLES=1 and WAIT_CYCLES=3 instances.
module tb_mem_port_arbiter;

   logic clk;
   logic rst_n;
   logic mem_clr;

   int n_tests;
   int n_fail;

   // WAIT_CYCLES=1 instance
   logic        if_req1, ls_req1, ls_we1;
   logic [31:0] if_addr1, ls_addr1, ls_wdata1;
   logic [31:0] if_rdata1, ls_rdata1, mem_addr1, mem_din1, mem_dout1;
   logic        if_ack1, ls_ack1, mem_we1, busy1;

   // WAIT_CYCLES=3 instance
   logic        if_req3, ls_req3, ls_we3;
   logic [31:0] if_addr3, ls_addr3, ls_wdata3;
   logic [31:0] if_rdata3, ls_rdata3, mem_addr3, mem_din3, mem_dout3;
   logic        if_ack3, ls_ack3, mem_we3, busy3;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
      .ls_req(ls_req1), .ls_we(ls_we1), .ls_addr(ls_addr1), .ls_wdata(ls_wdata1),
      .ls_rdata(ls_rdata1), .ls_ack(ls_ack1),
      .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_dout(mem_dout1),
      .busy(busy1)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_ack(if_ack3),
      .ls_req(ls_req3), .ls_we(ls_we3), .ls_addr(ls_addr3), .ls_wdata(ls_wdata3),
      .ls_rdata(ls_rdata3), .ls_ack(ls_ack3),
      .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_din(mem_din3), .mem_dout(mem_dout3),
      .busy(busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Power-on contents of unwritten locations
   function automatic logic [31:0] init_val(input logic [5:0] a);
      case (a)
         6'd4:    init_val = 32'h0000_1234;
         6'd16:   init_val = 32'h0000_BEEF;
         6'd24:   init_val = 32'h0000_7777;
         default: init_val = {26'h0, a};
      endcase
   endfunction

   // Word-per-address memory models, combinational read
   logic [31:0] mem1 [64];
   logic [63:0] vld1;
   logic [31:0] mem3 [64];
   logic [63:0] vld3;

   always @(posedge clk) begin
      if (mem_clr) begin
         vld1 <= '0;
         vld3 <= '0;
      end else begin
         if (mem_we1) begin
            mem1[mem_addr1[5:0]] <= mem_din1;
            vld1[mem_addr1[5:0]] <= 1'b1;
         end
         if (mem_we3) begin
            mem3[mem_addr3[5:0]] <= mem_din3;
            vld3[mem_addr3[5:0]] <= 1'b1;
         end
      end
   end

   assign mem_dout1 = vld1[mem_addr1[5:0]] ? mem1[mem_addr1[5:0]] : init_val(mem_addr1[5:0]);
   assign mem_dout3 = vld3[mem_addr3[5:0]] ? mem3[mem_addr3[5:0]] : init_val(mem_addr3[5:0]);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          ls;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;  // winner's rdata after ack
      logic [31:0] exp_other;  // non-winner's rdata, must be untouched
      int          exp_we;     // cycles with mem_we high
   } vec_t;

   vec_t vecs[6];

   // One isolated transaction on dut1; latency counted from the request cycle
   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      int wec;
      lat = -1;
      wec = 0;
      @(posedge clk); #1;
      if (v.ls) begin
         ls_req1 = 1'b1; ls_we1 = v.we; ls_addr1 = v.addr; ls_wdata1 = v.wdata;
      end else begin
         if_req1 = 1'b1; if_addr1 = v.addr;
      end
      for (int k = 0; k < 20 && lat < 0; k++) begin
         @(negedge clk);
         if (mem_we1) wec++;
         if (v.ls ? ls_ack1 : if_ack1) lat = k;
      end
      @(posedge clk); #1;
      if_req1 = 1'b0;
      ls_req1 = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_ack_pulse", idx), {30'h0, if_ack1, ls_ack1}, 32'h0);
      chk($sformatf("vec%0d_latency", idx), lat, 32'd2);
      chk($sformatf("vec%0d_mem_we_cycles", idx), wec, v.exp_we);
      chk($sformatf("vec%0d_rdata", idx), v.ls ? ls_rdata1 : if_rdata1, v.exp_rdata);
      chk($sformatf("vec%0d_other_rdata", idx), v.ls ? if_rdata1 : ls_rdata1, v.exp_other);
   endtask

   initial begin
      int acks;
      int cyc[6];
      bit who[6];
      int lsk;
      int ifk;
      int lsn;
      int ifn;
      int ackn;

      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      mem_clr = 1'b1;
      if_req1 = 0; ls_req1 = 0; ls_we1 = 0; if_addr1 = 0; ls_addr1 = 0; ls_wdata1 = 0;
      if_req3 = 0; ls_req3 = 0; ls_we3 = 0; if_addr3 = 0; ls_addr3 = 0; ls_wdata3 = 0;

      vecs[0] = '{ls: 0, we: 0, addr: 4,  wdata: 0,     exp_rdata: 32'h1234, exp_other: 0,        exp_we: 0};
      vecs[1] = '{ls: 1, we: 1, addr: 12, wdata: 'hCAFE, exp_rdata: 0,       exp_other: 32'h1234, exp_we: 1};
      vecs[2] = '{ls: 1, we: 0, addr: 12, wdata: 0,     exp_rdata: 32'hCAFE, exp_other: 32'h1234, exp_we: 0};
      vecs[3] = '{ls: 1, we: 1, addr: 20, wdata: 'h5555, exp_rdata: 32'hCAFE, exp_other: 32'h1234, exp_we: 1};
      vecs[4] = '{ls: 0, we: 0, addr: 12, wdata: 0,     exp_rdata: 32'hCAFE, exp_other: 32'hCAFE, exp_we: 0};
      vecs[5] = '{ls: 1, we: 0, addr: 20, wdata: 0,     exp_rdata: 32'h5555, exp_other: 32'hCAFE, exp_we: 0};

      // Reset state
      @(negedge clk);
      chk("reset_flags", {28'h0, if_ack1, ls_ack1, mem_we1, busy1}, 32'h0);
      chk("reset_mem_addr", mem_addr1, 32'h0);
      chk("reset_if_rdata", if_rdata1, 32'h0);
      @(posedge clk); #1;
      mem_clr = 1'b0;
      rst_n   = 1'b1;

      // Single transactions
      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Fairness: both held high, last grant was LS so IF goes first
      @(posedge clk); #1;
      if_req1 = 1'b1; if_addr1 = 4; ls_req1 = 1'b1; ls_we1 = 1'b0; ls_addr1 = 4;
      acks = 0;
      ackn = 0;
      for (int i = 0; i < 6; i++) begin cyc[i] = -1; who[i] = 1'b0; end
      for (int k = 0; k < 40 && acks < 6; k++) begin
         @(negedge clk);
         if (if_ack1 && ls_ack1) ackn++;
         if (if_ack1 || ls_ack1) begin
            cyc[acks] = k;
            who[acks] = ls_ack1;
            acks++;
         end
      end
      @(posedge clk); #1;
      if_req1 = 1'b0;
      ls_req1 = 1'b0;
      chk("rr_grant_count", acks, 32'd6);
      chk("rr_dual_ack", ackn, 32'd0);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("rr_who%0d", i), {31'h0, who[i]}, (i % 2));
         chk($sformatf("rr_cycle%0d", i), cyc[i], 2 + 3 * i);
      end

      // Address change while granted has no effect
      @(negedge clk);
      @(posedge clk); #1;
      if_req1 = 1'b1; if_addr1 = 4;
      @(posedge clk); #1;
      if_addr1 = 24;
      @(negedge clk);
      chk("addr_latched_mem_addr", mem_addr1, 32'd4);
      ifk = -1;
      for (int k = 1; k < 20 && ifk < 0; k++) begin
         if (if_ack1) ifk = k;
         else @(negedge clk);
      end
      @(posedge clk); #1;
      if_req1 = 1'b0;
      chk("addr_latched_ack_cycle", ifk, 32'd2);
      chk("addr_latched_rdata", if_rdata1, 32'h1234);

      // WAIT_CYCLES=3: IF request arriving mid-ACCESS waits its turn
      @(posedge clk); #1;
      ls_req3 = 1'b1; ls_we3 = 1'b0; ls_addr3 = 16; if_addr3 = 4;
      lsk = -1; ifk = -1; lsn = 0; ifn = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (k == 0) chk("w3_busy_idle", {31'h0, busy3}, 32'h0);
         if (k == 1) chk("w3_busy_access", {31'h0, busy3}, 32'h1);
         if (ls_ack3) begin lsn++; if (lsk < 0) lsk = k; end
         if (if_ack3) begin ifn++; if (ifk < 0) ifk = k; end
         @(posedge clk); #1;
         if (k + 1 == 2) if_req3 = 1'b1;
         if (lsk == k) ls_req3 = 1'b0;
         if (ifk == k) if_req3 = 1'b0;
      end
      chk("w3_ls_ack_cycle", lsk, 32'd4);
      chk("w3_if_ack_cycle", ifk, 32'd9);
      chk("w3_ack_counts", {ifn[15:0], lsn[15:0]}, 32'h0001_0001);
      chk("w3_ls_rdata", ls_rdata3, 32'hBEEF);
      chk("w3_if_rdata", if_rdata3, 32'h1234);

      // Reset in the middle of an LS write
      @(posedge clk); #1;
      ls_req1 = 1'b1; ls_we1 = 1'b1; ls_addr1 = 8; ls_wdata1 = 32'hDEAD;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_mid_pre_we", {31'h0, mem_we1}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_flags", {28'h0, if_ack1, ls_ack1, mem_we1, busy1}, 32'h0);
      chk("rst_mid_mem_addr", mem_addr1, 32'h0);
      chk("rst_mid_mem_din", mem_din1, 32'h0);
      chk("rst_mid_if_rdata", if_rdata1, 32'h0);
      chk("rst_mid_ls_rdata", ls_rdata1, 32'h0);
      @(posedge clk); #1;
      ls_req1 = 1'b0;
      rst_n   = 1'b1;
      lsn = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ls_ack1 || busy1) lsn++;
      end
      chk("rst_mid_no_ack", lsn, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
